dec_drive_seq: RTL and testbench

Sequencer that sits directly upstream of the 2x4 negative-enable decoder. It drives the decoder's 2-bit select and active-low enable either once (single code) or across all four codes (scan). For each code it holds the drive for a programmable dwell time, then samples the 1-bit function result fed back from downstream into a 4-bit result vector, one bit per code. Used to sweep or strobe decoder outputs and capture F per code.

---
 rtl/dec_drive_seq.sv | 134 +++++++++++++
 tb/tb_dec_drive_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dec_drive_seq.sv
// Sequencer for the 2x4 negative-enable decoder: drives one code (single)
// or codes 0..3 (scan), holds each for a dwell time and captures the
// downstream function result per code.
module dec_drive_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [1:0]       code_in,
  input  logic [CNT_W-1:0] dwell,
  input  logic             fb_in,
  output logic [1:0]       sel,
  output logic             en_n,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_n_q, en_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] dwell_eff_q, dwell_eff_d;
  logic [CNT_W-1:0] dwell_eff_in;

  // A dwell of zero is treated as a single cycle
  assign dwell_eff_in = (dwell == '0) ? CNT_W'(1) : dwell;

  // State register; async reset releases the decoder (en_n high) at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      en_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      dwell_eff_q <= CNT_W'(1);
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      en_n_q      <= en_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      dwell_eff_q <= dwell_eff_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    en_n_d      = en_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    dwell_eff_d = dwell_eff_q;

    case (state_q)
      ST_IDLE: begin
        en_n_d = 1'b1;
        busy_d = 1'b0;
        if (start && !abort) begin
          mode_d      = mode;
          dwell_eff_d = dwell_eff_in;
          result_d    = '0;
          sel_d       = mode ? 2'd0 : code_in;
          cnt_d       = dwell_eff_in - CNT_W'(1);
          en_n_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          // Bit for the code in progress is left unwritten
          en_n_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d[sel_q] = fb_in;
          if (mode_q && (sel_q != 2'd3)) begin
            sel_d = sel_q + 2'd1;
            cnt_d = dwell_eff_q - CNT_W'(1);
          end else begin
            en_n_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        en_n_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        en_n_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sel    = sel_q;
  assign en_n   = en_n_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_dec_drive_seq.sv
// Bench for dec_drive_seq: table of runs checked through a result
// scoreboard, plus hand-written reset, abort and start+abort sequences.
module tb_dec_drive_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, mode;
  logic [1:0] code_in;
  logic [7:0] dwell;
  logic       fb_in;
  logic [1:0] sel;
  logic       en_n, busy, done;
  logic [3:0] result;

  logic [3:0] fbmap = 4'b0000;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic       mode;
    logic [1:0] code;
    logic [7:0] dwell;
    logic [3:0] fb;
    int         repulse;
    logic [3:0] exp_result;
    int         exp_busy;
  } vec_t;

  typedef struct {
    logic [3:0] result;
    int         busy_cycles;
  } exp_t;

  exp_t sb_q[$];

  dec_drive_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .code_in(code_in), .dwell(dwell), .fb_in(fb_in), .sel(sel),
    .en_n(en_n), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Downstream function: F per code taken from the current select
  assign fb_in = fbmap[sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one run and follow it to its done pulse
  task automatic run(input vec_t v);
    int   nb;
    int   nd;
    int   deff;
    exp_t e;
    bit   finished;
    deff = (v.dwell == 0) ? 1 : int'(v.dwell);
    fbmap = v.fb;
    e.result = v.exp_result;
    e.busy_cycles = v.exp_busy;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; mode = v.mode; code_in = v.code; dwell = v.dwell;
    @(negedge clk);
    start = 1'b0; mode = ~v.mode; code_in = ~v.code; dwell = 8'd7;
    nb = 0; nd = 0; finished = 0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      if (busy) begin
        nb++;
        chk("drive_en_n", 32'(en_n), 32'd0);
        chk("drive_sel", 32'(sel), v.mode ? 32'((nb - 1) / deff) : 32'(v.code));
      end
      if (done) begin
        nd++;
        chk("done_en_n", 32'(en_n), 32'd1);
        e = sb_q.pop_front();
        chk("result", 32'(result), 32'(e.result));
        chk("busy_cycles", 32'(nb), 32'(e.busy_cycles));
      end else if (nd != 0) begin
        chk("done_once", 32'(nd), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        finished = 1;
      end
      if (!finished) begin
        start = (v.repulse != 0 && nb == v.repulse);
        if (start) mode = ~mode;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!finished) begin
      chk("run_timeout", 32'd1, 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b0, 2'd2, 8'd3,   4'b1111, 0, 4'b0100, 3};
    vecs[1] = '{1'b1, 2'd0, 8'd1,   4'b0110, 0, 4'b0110, 4};
    vecs[2] = '{1'b1, 2'd3, 8'd0,   4'b1010, 0, 4'b1010, 4};
    vecs[3] = '{1'b0, 2'd1, 8'd3,   4'b0010, 2, 4'b0010, 3};
    vecs[4] = '{1'b1, 2'd2, 8'd3,   4'b1001, 5, 4'b1001, 12};
    vecs[5] = '{1'b0, 2'd3, 8'd255, 4'b0000, 0, 4'b0000, 255};
    vecs[6] = '{1'b0, 2'd0, 8'd0,   4'b0001, 0, 4'b0001, 1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    code_in = 2'd0; dwell = 8'd1;
    repeat (2) @(negedge clk);
    chk("rst_en_n", 32'(en_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Abort on the 2nd cycle of sel=2 in a dwell-2 scan
    fbmap = 4'b1111;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; dwell = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_sel", 32'(sel), 32'd2);
    chk("abort_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_en_n", 32'(en_n), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'h3);
    begin
      int nd = 0;
      for (int c = 0; c < 4; c++) begin
        if (done) nd++;
        @(negedge clk);
      end
      chk("abort_no_done", 32'(nd), 32'd0);
    end

    // start and abort together in IDLE are not accepted
    start = 1'b1; abort = 1'b1; mode = 1'b0; code_in = 2'd1; dwell = 8'd2;
    begin
      int nlow = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (en_n !== 1'b1 || busy !== 1'b0) nlow++;
      end
      chk("start_abort_idle", 32'(nlow), 32'd0);
    end
    start = 1'b0; abort = 1'b0;

    // Asynchronous reset mid-scan, checked between clock edges
    fbmap = 4'b1111;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; dwell = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("prerst_en_n", 32'(en_n), 32'd0);
    chk("prerst_result", 32'(result), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en_n", 32'(en_n), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_en_n", 32'(en_n), 32'd1);
    chk("postrst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
